// File: rtl/operand_fetch_stage_pkg.sv
// operand_fetch_stage_pkg
// Shared definitions for the operand fetch stage and the execute ALU:
// default widths, the R-type opcode, the supported funct codes and the
// bit positions of each MIPS instruction field.
// No ports (package).

package operand_fetch_stage_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int REG_N_DEF  = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int CNT_W_DEF  = 16;

    localparam logic [5:0] OPC_RTYPE = 6'b000000;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 26;
    localparam int RS_MSB  = 25;
    localparam int RS_LSB  = 21;
    localparam int RT_MSB  = 20;
    localparam int RT_LSB  = 16;
    localparam int RD_MSB  = 15;
    localparam int RD_LSB  = 11;
    localparam int SH_MSB  = 10;
    localparam int SH_LSB  = 6;
    localparam int FN_MSB  = 5;
    localparam int FN_LSB  = 0;

    // An instruction is supported only if it is R-type with one of the
    // six ALU funct codes; everything else is treated as illegal.
    function automatic logic is_legal(input logic [5:0] opc, input logic [5:0] fn);
        logic fn_ok;
        fn_ok = (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
                (fn == FN_OR)  || (fn == FN_NOR) || (fn == FN_SLT);
        return (opc == OPC_RTYPE) && fn_ok;
    endfunction

endpackage

// File: rtl/operand_fetch_stage_regfile_2r1w.sv
// regfile_2r1w
// Register file with two combinational read ports and one write port.
// Register 0 always reads as zero and ignores writes. A read of the
// register being written in the same cycle returns the write data.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   i_wr_en/addr/data         write port (takes effect on the clock edge)
//   i_rd_addr_a, o_rd_data_a  read port A
//   i_rd_addr_b, o_rd_data_b  read port B

module regfile_2r1w
    import operand_fetch_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_N  = REG_N_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr_a,
    output logic [DATA_W-1:0] o_rd_data_a,
    input  logic [ADDR_W-1:0] i_rd_addr_b,
    output logic [DATA_W-1:0] o_rd_data_b
);

    logic [DATA_W-1:0] r_regs [REG_N];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_N; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_wr_en && (i_wr_addr != '0)) begin
            r_regs[i_wr_addr] <= i_wr_data;
        end
    end

    // Write-through: the value being written this cycle is visible to readers
    // immediately, so a consumer never has to wait the extra cycle.
    always_comb begin
        o_rd_data_a = r_regs[i_rd_addr_a];
        o_rd_data_b = r_regs[i_rd_addr_b];
        if (i_wr_en && (i_wr_addr == i_rd_addr_a)) o_rd_data_a = i_wr_data;
        if (i_wr_en && (i_wr_addr == i_rd_addr_b)) o_rd_data_b = i_wr_data;
        if (i_rd_addr_a == '0) o_rd_data_a = '0;
        if (i_rd_addr_b == '0) o_rd_data_b = '0;
    end

endmodule

// File: rtl/operand_fetch_stage.sv
// operand_fetch_stage
// Decodes MIPS R-type instructions, reads rs/rt from the register file
// (with writeback bypass), stalls on pending-register hazards and hands
// in1/in2/op/rd to the execute ALU through a registered valid/ready port.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   i_instr_valid, o_instr_ready  upstream handshake; i_instr is the word
//   o_ex_valid, i_ex_ready        downstream handshake
//   o_ex_in1, o_ex_in2            rs and rt values
//   o_ex_op, o_ex_rd              funct code and destination register
//   i_wb_en, i_wb_addr, i_wb_data writeback port
//   o_illegal                     one-cycle pulse per consumed illegal instr
//   o_illegal_cnt                 saturating count of illegal instructions

module operand_fetch_stage
    import operand_fetch_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_N  = REG_N_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_instr_valid,
    output logic              o_instr_ready,
    input  logic [31:0]       i_instr,
    output logic              o_ex_valid,
    input  logic              i_ex_ready,
    output logic [DATA_W-1:0] o_ex_in1,
    output logic [DATA_W-1:0] o_ex_in2,
    output logic [5:0]        o_ex_op,
    output logic [ADDR_W-1:0] o_ex_rd,
    input  logic              i_wb_en,
    input  logic [ADDR_W-1:0] i_wb_addr,
    input  logic [DATA_W-1:0] i_wb_data,
    output logic              o_illegal,
    output logic [CNT_W-1:0]  o_illegal_cnt
);

    logic [5:0]        w_opc;
    logic [ADDR_W-1:0] w_rs;
    logic [ADDR_W-1:0] w_rt;
    logic [ADDR_W-1:0] w_rd;
    logic [5:0]        w_fn;
    logic              w_unused_shamt;
    logic              w_legal;
    logic [REG_N-1:0]  w_pend_eff;
    logic [REG_N-1:0]  w_pend_next;
    logic              w_hazard;
    logic              w_out_free;
    logic              w_issue;
    logic              w_consume_bad;
    logic [DATA_W-1:0] w_rs_val;
    logic [DATA_W-1:0] w_rt_val;

    logic [REG_N-1:0]  r_pending;
    logic              r_ex_valid;
    logic [DATA_W-1:0] r_ex_in1;
    logic [DATA_W-1:0] r_ex_in2;
    logic [5:0]        r_ex_op;
    logic [ADDR_W-1:0] r_ex_rd;
    logic              r_illegal;
    logic [CNT_W-1:0]  r_illegal_cnt;

    assign w_opc          = i_instr[OPC_MSB:OPC_LSB];
    assign w_rs           = i_instr[RS_MSB:RS_LSB];
    assign w_rt           = i_instr[RT_MSB:RT_LSB];
    assign w_rd           = i_instr[RD_MSB:RD_LSB];
    assign w_fn           = i_instr[FN_MSB:FN_LSB];
    assign w_unused_shamt = ^i_instr[SH_MSB:SH_LSB];
    assign w_legal        = is_legal(w_opc, w_fn);

    regfile_2r1w #(
        .DATA_W (DATA_W),
        .REG_N  (REG_N),
        .ADDR_W (ADDR_W)
    ) u_regfile (
        .clk         (clk),
        .rst         (rst),
        .i_wr_en     (i_wb_en),
        .i_wr_addr   (i_wb_addr),
        .i_wr_data   (i_wb_data),
        .i_rd_addr_a (w_rs),
        .o_rd_data_a (w_rs_val),
        .i_rd_addr_b (w_rt),
        .o_rd_data_b (w_rt_val)
    );

    // A register whose result is being written back this very cycle is no
    // longer a hazard, since the bypass delivers the value in time. The
    // next pending vector applies the clear first so a same-cycle issue to
    // the same register wins.
    always_comb begin
        w_pend_eff  = r_pending;
        w_pend_next = r_pending;
        if (i_wb_en) begin
            w_pend_eff[i_wb_addr]  = 1'b0;
            w_pend_next[i_wb_addr] = 1'b0;
        end
        if (w_issue && (w_rd != '0)) begin
            w_pend_next[w_rd] = 1'b1;
        end
        w_pend_next[0] = 1'b0;
    end

    assign w_hazard   = w_pend_eff[w_rs] | w_pend_eff[w_rt] | w_pend_eff[w_rd];
    assign w_out_free = !r_ex_valid || i_ex_ready;

    // Ready depends only on the instruction word and state, never on
    // i_instr_valid; illegal words are drained without a hazard check.
    assign o_instr_ready = !rst && w_out_free && (!w_legal || !w_hazard);
    assign w_issue       = i_instr_valid && o_instr_ready && w_legal;
    assign w_consume_bad = i_instr_valid && o_instr_ready && !w_legal;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pend_next;
        end
    end

    // Output register: load on issue, drop valid once the ALU has taken the
    // word and nothing replaces it, otherwise hold everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex_valid <= 1'b0;
            r_ex_in1   <= '0;
            r_ex_in2   <= '0;
            r_ex_op    <= '0;
            r_ex_rd    <= '0;
        end else if (w_issue) begin
            r_ex_valid <= 1'b1;
            r_ex_in1   <= w_rs_val;
            r_ex_in2   <= w_rt_val;
            r_ex_op    <= w_fn;
            r_ex_rd    <= w_rd;
        end else if (i_ex_ready) begin
            r_ex_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_illegal     <= 1'b0;
            r_illegal_cnt <= '0;
        end else begin
            r_illegal <= w_consume_bad;
            if (w_consume_bad && (r_illegal_cnt != '1)) begin
                r_illegal_cnt <= r_illegal_cnt + 1'b1;
            end
        end
    end

    assign o_ex_valid    = r_ex_valid;
    assign o_ex_in1      = r_ex_in1;
    assign o_ex_in2      = r_ex_in2;
    assign o_ex_op       = r_ex_op;
    assign o_ex_rd       = r_ex_rd;
    assign o_illegal     = r_illegal;
    assign o_illegal_cnt = r_illegal_cnt;

endmodule

// File: doc/operand_fetch_stage.md
Name: operand_fetch_stage

Overview:
- Upstream neighbour of the execute ALU. Accepts 32-bit MIPS R-type instructions over a valid/ready handshake and decodes rs, rt, rd and funct.
- Reads operands from an internal 32x32 register file with write-through bypass from writeback, and blocks RAW/WAW hazards with a per-register pending scoreboard.
- Presents registered in1/in2/op/rd to the ALU through a valid/ready output register.

Parameters:
- DATA_W, 32, operand and register width.
- REG_N, 32, number of architectural registers.
- ADDR_W, 5, register index width (log2 REG_N).
- CNT_W, 16, width of the illegal-instruction counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- instr_valid  in  1  upstream instruction valid.
- instr_ready  out  1  stage accepts instr this cycle.
- instr  in  32  instruction word, MIPS field layout (opcode = 6 MSBs, then rs, rt, rd, shamt, funct).
- ex_valid  out  1  ALU operands valid.
- ex_ready  in  1  ALU/next stage accepts.
- ex_in1  out  DATA_W  value of rs.
- ex_in2  out  DATA_W  value of rt.
- ex_op  out  6  funct code passed to the ALU.
- ex_rd  out  ADDR_W  destination register.
- wb_en  in  1  writeback strobe.
- wb_addr  in  ADDR_W  writeback register.
- wb_data  in  DATA_W  writeback value.
- illegal  out  1  one-cycle pulse when an unsupported instruction is consumed.
- illegal_cnt  out  CNT_W  saturating count of illegal instructions.

Behaviour:
- Reset (async, immediate):
  - All registers, pending bits, ex_* outputs, illegal and illegal_cnt go to 0.
  - instr_ready is 0 while rst is high.
  - Reset mid-operation discards the held output word and all pending bits.
- Legal instruction:
  - Opcode must be 000000 and funct one of 100000 add, 100010 sub, 100100 and, 100101 or, 100111 nor, 101010 slt.
  - Anything else is illegal.
- Register file:
  - r0 reads as 0 and writes to it are ignored.
  - A write occurs on the clk edge when wb_en=1.
  - Reads are combinational. When wb_en and wb_addr equals the read index (not 0), the read returns wb_data (write-through bypass).
- Scoreboard:
  - pending[i] is set when an instruction with rd=i (i≠0) issues.
  - pending[i] is cleared on wb_en with wb_addr=i.
  - Effective pending = pending[i] AND NOT (wb_en AND wb_addr==i).
  - Same-cycle set and clear on the same register: set wins.
- Hazard (legal instruction only): the effective pending bit of rs, rt or rd is set. r0 never hazards.
- out_free = !ex_valid OR ex_ready.
- instr_ready:
  - Illegal instruction: instr_ready = out_free.
  - Legal instruction: instr_ready = out_free AND !hazard.
  - instr_ready is combinational from instr and state; no combinational path from instr_valid.
- Issue (instr_valid AND instr_ready AND legal), on the next edge:
  - ex_valid=1.
  - ex_in1/ex_in2 = bypassed read values.
  - ex_op = funct.
  - ex_rd = rd.
  - pending[rd] is set.
- Consume of an illegal instruction:
  - No issue and no scoreboard change.
  - illegal=1 for exactly the next cycle.
  - illegal_cnt increments and saturates at all-ones.
- Output register:
  - Holds all ex_* values stable while ex_valid AND !ex_ready.
  - Clears ex_valid when ex_ready=1 and nothing issues.
- Latency: 1 cycle from accept to ex_valid. Throughput is 1 per cycle when free of hazards.
- The ALU's own register adds 1 cycle downstream. wb is driven by the writeback stage.

Decomposition:
- Shared package holds:
  - Funct constants FN_ADD, FN_SUB, FN_AND, FN_OR, FN_NOR, FN_SLT.
  - OPC_RTYPE.
  - Field-position constants for opcode, rs, rt, rd and funct.
  - DATA_W and ADDR_W defaults.
  - The ALU consumes the same funct constants.
- One sub-module, regfile_2r1w: 2 combinational read ports, 1 write port, r0 hardwired to 0, write-through bypass, async reset.
- Decode, scoreboard and output register stay in the top level.

Test Plan:
- Writes and issue: wb writes r1=5 and r2=7, then issue add r3,r1,r2. Required: next cycle ex_valid=1, ex_in1=5, ex_in2=7, ex_op=100000, ex_rd=3.
- RAW hazard: issue add r3, then immediately present sub r4,r3,r1. Required: instr_ready=0 until wb_en with wb_addr=3 and wb_data=12; in that wb cycle instr_ready=1 and ex_in1=12 via the bypass.
- Backpressure: ex_ready=0 for 4 cycles with two instructions queued. Required: ex_* stable, instr_ready=0; when ex_ready rises the second instruction appears the cycle after.
- r0 handling: wb writes r0=99, then issue or r5,r0,r0. Required: ex_in1=ex_in2=0, no hazard on r0, pending[0] never set.
- Illegal instructions: opcode 100011 (lw), then funct 000000. Required: each is consumed with a one-cycle illegal pulse, illegal_cnt=2, ex_valid stays 0. Also preload the counter to all-ones and confirm it saturates.
- Reset mid-operation: assert rst while ex_valid=1 and pending[3]=1. Required: outputs 0 immediately; after release, reg 3 does not hazard and all registers read 0.
